// File: rtl/sram_slave_port.sv
// sram_slave_port: responder for an SRAM-style CPU memory port.
//
// Ordinary addresses are served from an internal word RAM with byte-lane writes. A 64 KiB
// window selected by sram_addr[31:16] == MMIO_HI holds four peripheral registers:
//   0x0000 LED      RW, lanes 0-1 only (lanes 2-3 read as 0)
//   0x0004 SWITCH   RO, synchronised switch inputs
//   0x0008 TIMER    RW, free-running 32-bit counter
//   0x000C SCRATCH  RW, 32-bit
// Every access is read-before-write: sram_rdata loads the word as it was before this
// cycle's update, one cycle after the request, and holds until the next request.
//
// Ports:
//   clk         clock, rising edge
//   resetn      asynchronous active-low reset
//   sram_en     access request this cycle
//   sram_wen    byte write enables (0 = read)
//   sram_addr   byte address, bits [1:0] ignored
//   sram_wdata  write data
//   sram_rdata  registered read data
//   led         LED register
//   switch      asynchronous switch inputs
module sram_slave_port #(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam int unsigned Depth = 1 << ADDR_W;

  // Merge the enabled byte lanes of new_val into old_val.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode
  logic              is_mmio;
  logic [ADDR_W-1:0] ram_idx;
  logic [13:0]       mmio_word;
  logic              wr_req;
  logic              unused_addr;

  assign is_mmio     = (sram_addr[31:16] == MMIO_HI);
  assign ram_idx     = sram_addr[ADDR_W+1:2];
  assign mmio_word   = sram_addr[15:2];
  assign wr_req      = sram_en && (sram_wen != 4'b0000);
  assign unused_addr = ^sram_addr[1:0];

  logic sel_led, sel_timer, sel_scratch;
  assign sel_led     = is_mmio && (mmio_word == 14'd0);
  assign sel_timer   = is_mmio && (mmio_word == 14'd2);
  assign sel_scratch = is_mmio && (mmio_word == 14'd3);

  // State
  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  // Read path
  logic [31:0] mmio_rdata;
  logic [31:0] rd_word;

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_word)
      14'd0:   mmio_rdata = {16'h0, led_q};
      14'd1:   mmio_rdata = {24'h0, sw_sync_q};
      14'd2:   mmio_rdata = timer_q;
      14'd3:   mmio_rdata = scratch_q;
      default: mmio_rdata = 32'h0;
    endcase
  end

  // mem_q is read combinationally before the edge, so writes are naturally read-before-write.
  assign rd_word = is_mmio ? mmio_rdata : mem_q[ram_idx];

  // Next state
  always_comb begin
    rdata_d   = rdata_q;
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    scratch_d = scratch_q;

    if (sram_en) rdata_d = rd_word;

    if (wr_req && sel_led) begin
      if (sram_wen[0]) led_d[7:0]  = sram_wdata[7:0];
      if (sram_wen[1]) led_d[15:8] = sram_wdata[15:8];
    end

    // A write replaces this cycle's increment.
    if (wr_req && sel_timer) timer_d = lane_merge(timer_q, sram_wdata, sram_wen);

    if (wr_req && sel_scratch) scratch_d = lane_merge(scratch_q, sram_wdata, sram_wen);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      timer_q   <= 32'h0;
      scratch_q <= 32'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_req && !is_mmio) begin
      mem_q[ram_idx] <= lane_merge(mem_q[ram_idx], sram_wdata, sram_wen);
    end
  end

  assign sram_rdata = rdata_q;
  assign led        = led_q;

endmodule

// File: tb/tb_sram_slave_port.sv
module tb_sram_slave_port;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch = 8'h0;

  always #5 clk = ~clk;

  sram_slave_port #(
    .ADDR_W (12),
    .MMIO_HI(16'hBFAF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sram_en   (sram_en),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .led       (led),
    .switch    (switch)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a sparse word map, registers as plain variables.
  logic [31:0] m_ram [int];
  logic [31:0] m_timer, m_scratch, m_rdata;
  logic [15:0] m_led;
  logic [7:0]  m_sw_meta, m_sw_sync;
  bit          m_rd_known;

  function automatic logic [31:0] lanes(input logic [3:0] w);
    return {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] w);
    return (old_v & ~lanes(w)) | (new_v & lanes(w));
  endfunction

  task automatic m_reset();
    m_timer    = 32'h0;
    m_scratch  = 32'h0;
    m_rdata    = 32'h0;
    m_led      = 16'h0;
    m_sw_meta  = 8'h0;
    m_sw_sync  = 8'h0;
    m_rd_known = 1'b1;
  endtask

  // Drive one cycle, advance the model across the same edge, and compare.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [7:0] sw);
    bit          mm;
    logic [15:0] off;
    int          idx;
    logic [31:0] tmp;
    bit          timer_wr;
    sram_en    = en;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wd;
    switch     = sw;
    mm  = (addr[31:16] == 16'hBFAF);
    off = addr[15:0] & 16'hFFFC;
    idx = int'((addr >> 2) % 4096);
    if (en) begin
      m_rd_known = 1'b1;
      if (mm) begin
        case (off)
          16'h0000: m_rdata = {16'h0, m_led};
          16'h0004: m_rdata = {24'h0, m_sw_sync};
          16'h0008: m_rdata = m_timer;
          16'h000C: m_rdata = m_scratch;
          default:  m_rdata = 32'h0;
        endcase
      end else if (m_ram.exists(idx)) begin
        m_rdata = m_ram[idx];
      end else begin
        m_rd_known = 1'b0;
      end
    end
    timer_wr = 1'b0;
    if (en && wen != 4'h0) begin
      if (!mm) begin
        tmp = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
        // A partial write to an unknown word leaves unknown bytes; only track full writes.
        if (m_ram.exists(idx) || wen == 4'hF) m_ram[idx] = merge(tmp, wd, wen);
      end else begin
        case (off)
          16'h0000: begin
            tmp   = merge({16'h0, m_led}, wd, wen & 4'b0011);
            m_led = tmp[15:0];
          end
          16'h0008: begin
            m_timer  = merge(m_timer, wd, wen);
            timer_wr = 1'b1;
          end
          16'h000C: m_scratch = merge(m_scratch, wd, wen);
          default: ;
        endcase
      end
    end
    if (!timer_wr) m_timer = m_timer + 32'd1;
    m_sw_sync = m_sw_meta;
    m_sw_meta = sw;
    @(posedge clk);
    #1;
    if (m_rd_known) check32("model rdata", sram_rdata, m_rdata);
    check32("model led", {16'h0, led}, {16'h0, m_led});
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic        chk;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [7:0] sw, input logic chk,
                              input logic [31:0] exp_rd, input logic [15:0] exp_led);
    vec_t v;
    v.en = en; v.wen = wen; v.addr = addr; v.wdata = wd; v.sw = sw;
    v.chk = chk; v.exp_rd = exp_rd; v.exp_led = exp_led;
    return v;
  endfunction

  initial begin
    // Byte lanes, read-before-write, wen without en
    vecs.push_back(mk(1, 4'hF, 32'h0000_0010, 32'h1122_3344, 8'h00, 0, 32'h0,         16'h0));
    vecs.push_back(mk(1, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 8'h00, 1, 32'h1122_3344, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'h0000_0010, 32'h0,         8'h00, 1, 32'h11BB_33DD, 16'h0));
    // Latency and aliasing
    vecs.push_back(mk(1, 4'hF, 32'h0000_0014, 32'hDEAD_BEEF, 8'h00, 0, 32'h0,         16'h0));
    vecs.push_back(mk(1, 4'h0, 32'h0000_0014, 32'h0,         8'h00, 1, 32'hDEAD_BEEF, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'h0000_4014, 32'h0,         8'h00, 1, 32'hDEAD_BEEF, 16'h0));
    vecs.push_back(mk(0, 4'hF, 32'h0000_0010, 32'h0,         8'h00, 1, 32'hDEAD_BEEF, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'h0000_0010, 32'h0,         8'h00, 1, 32'h11BB_33DD, 16'h0));
    // Timer wrap
    vecs.push_back(mk(1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE, 8'h00, 0, 32'h0,         16'h0));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_0008, 32'h0,         8'h00, 1, 32'hFFFF_FFFE, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_0008, 32'h0,         8'h00, 1, 32'hFFFF_FFFF, 16'h0));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_0008, 32'h0,         8'h00, 1, 32'h0000_0000, 16'h0));
    // LED, SWITCH, unmapped, SCRATCH
    vecs.push_back(mk(1, 4'hF, 32'hBFAF_0000, 32'h1234_ABCD, 8'h00, 1, 32'h0,       16'hABCD));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_0000, 32'h0,         8'h00, 1, 32'hABCD,    16'hABCD));
    vecs.push_back(mk(0, 4'h0, 32'h0,         32'h0,         8'h5A, 1, 32'hABCD,    16'hABCD));
    vecs.push_back(mk(0, 4'h0, 32'h0,         32'h0,         8'h5A, 1, 32'hABCD,    16'hABCD));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_0004, 32'h0,         8'h5A, 1, 32'h5A,      16'hABCD));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_0010, 32'h0,         8'h5A, 1, 32'h0,       16'hABCD));
    vecs.push_back(mk(1, 4'hF, 32'hBFAF_0004, 32'hFF,        8'h5A, 1, 32'h5A,      16'hABCD));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_0004, 32'h0,         8'h5A, 1, 32'h5A,      16'hABCD));
    vecs.push_back(mk(1, 4'hF, 32'hBFAF_000C, 32'hCAFE_F00D, 8'h5A, 1, 32'h0,       16'hABCD));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_000C, 32'h0,         8'h5A, 1, 32'hCAFE_F00D, 16'hABCD));
    vecs.push_back(mk(1, 4'hC, 32'hBFAF_0000, 32'hFFFF_0000, 8'h5A, 1, 32'hABCD,    16'hABCD));
    vecs.push_back(mk(1, 4'h0, 32'hBFAF_0000, 32'h0,         8'h5A, 1, 32'hABCD,    16'hABCD));

    // Reset values
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check32("reset rdata", sram_rdata, 32'h0);
    check32("reset led", {16'h0, led}, 32'h0);
    resetn = 1'b1;
    step(1, 4'h0, 32'hBFAF_0008, 32'h0, 8'h00);
    check32("timer first read", sram_rdata, 32'h0);

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].sw);
      if (vecs[i].chk) check32($sformatf("vec%0d rdata", i), sram_rdata, vecs[i].exp_rd);
      check32($sformatf("vec%0d led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
    end

    // Reset while a SCRATCH write is pending
    sram_en    = 1'b1;
    sram_wen   = 4'hF;
    sram_addr  = 32'hBFAF_000C;
    sram_wdata = 32'h1234_5678;
    #2;
    resetn = 1'b0;
    #1;
    check32("midreset rdata", sram_rdata, 32'h0);
    check32("midreset led", {16'h0, led}, 32'h0);
    sram_en  = 1'b0;
    sram_wen = 4'h0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    m_reset();
    step(1, 4'h0, 32'hBFAF_0008, 32'h0, 8'h5A);
    check32("post-reset timer", sram_rdata, 32'h0);
    step(1, 4'h0, 32'hBFAF_000C, 32'h0, 8'h5A);
    check32("post-reset scratch", sram_rdata, 32'h0);
    step(1, 4'h0, 32'h0000_0010, 32'h0, 8'h5A);
    check32("post-reset ram kept", sram_rdata, 32'h11BB_33DD);

    // Randomised traffic against the model
    for (int k = 0; k < 16; k++) step(1, 4'hF, 32'h100 + 32'(4 * k), $urandom, 8'h5A);
    begin
      logic [7:0] sw_val;
      sw_val = 8'h5A;
      for (int n = 0; n < 400; n++) begin
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        en  = ($urandom_range(0, 4) != 0);
        wen = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        if ($urandom_range(0, 2) == 0) begin
          addr = 32'hBFAF_0000 | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
        end else begin
          addr = ((32'($urandom) & 32'h0003_C000) | (32'h100 + (32'($urandom_range(0, 15)) << 2)));
        end
        if ($urandom_range(0, 9) == 0) sw_val = 8'($urandom);
        step(en, wen, addr, $urandom, sw_val);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
